// File: rtl/cache_mem_arbiter_pkg.sv
// rtl/cache_mem_arbiter_pkg.sv - shared RAM/arbiter types for the cache memory arbiter
package cache_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISERV = 2'd1,
        DSERV = 2'd2
    } arb_state_t;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// rtl/cache_mem_arbiter_if.sv - cache-side and RAM-side signals of the cache memory arbiter
interface cache_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import cache_mem_arbiter_pkg::*;

    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              iwait;
    logic [DATA_W-1:0] iload;

    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              dwait;
    logic [DATA_W-1:0] dload;

    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    ramstate_t         ramstate;

    // arbiter view: serves the caches, drives the RAM
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    // environment view: caches plus RAM model
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/cache_arb_starve_ctr.sv
// rtl/cache_arb_starve_ctr.sv - saturating count of dcache wins while the icache waits
module cache_arb_starve_ctr #(
    parameter int LIMIT = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);
    localparam int W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign sat_o = (cnt_q == W'(LIMIT));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !sat_o) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - single-port RAM arbiter between icache and dcache, dcache priority
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input logic                CLK,
    input logic                nRST,
    cache_mem_arbiter_if.slave bus
);
    arb_state_t state_q, state_d;

    logic ireq, dreq, ram_done, starve_sat, cnt_inc, cnt_clr;

    assign ireq     = bus.iREN;
    assign dreq     = bus.dREN | bus.dWEN;
    assign ram_done = (bus.ramstate == ACCESS);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // completion always returns to IDLE so a stale request is never re-granted
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (dreq && !(ireq && starve_sat)) begin
                    state_d = DSERV;
                end else if (ireq) begin
                    state_d = ISERV;
                end
            end
            ISERV: if (!ireq || ram_done) state_d = IDLE;
            DSERV: if (!dreq || ram_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign cnt_inc = (state_q == IDLE) && (state_d == DSERV) && ireq;
    assign cnt_clr = (state_q == IDLE) && (state_d != IDLE) && !cnt_inc;

    cache_arb_starve_ctr #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve_ctr (
        .clk_i (CLK),
        .rst_ni(nRST),
        .inc_i (cnt_inc),
        .clr_i (cnt_clr),
        .sat_o (starve_sat)
    );

    always_comb begin
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.iload    = '0;
        bus.dload    = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        unique case (state_q)
            ISERV: begin
                bus.ramREN  = ireq;
                bus.ramaddr = bus.iaddr;
                if (ireq && ram_done) begin
                    bus.iwait = 1'b0;
                    bus.iload = bus.ramload;
                end
            end
            DSERV: begin
                bus.ramaddr = bus.daddr;
                if (bus.dWEN) begin
                    bus.ramWEN   = 1'b1;
                    bus.ramstore = bus.dstore;
                end else begin
                    bus.ramREN = bus.dREN;
                end
                if (dreq && ram_done) begin
                    bus.dwait = 1'b0;
                    bus.dload = bus.ramload;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - self-checking bench for cache_mem_arbiter
module tb_cache_mem_arbiter;
    import cache_mem_arbiter_pkg::*;

    localparam int LIMIT = 4;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    cache_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    cache_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .CLK (CLK),
        .nRST(nRST),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ir, dr, dw;
        logic [31:0] ia, da, ds, rl;
        logic [1:0]  rs;
        logic        e_iw, e_dw, e_ren, e_wen;
        logic [31:0] e_addr, e_store, e_il, e_dl;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic ir, dr, dw, input logic [31:0] ia, da, ds,
                                input logic [1:0] rs, input logic [31:0] rl,
                                input logic e_iw, e_dw, e_ren, e_wen,
                                input logic [31:0] e_addr, e_store, e_il, e_dl);
        vec_t v;
        v.ir = ir; v.dr = dr; v.dw = dw; v.ia = ia; v.da = da; v.ds = ds; v.rs = rs; v.rl = rl;
        v.e_iw = e_iw; v.e_dw = e_dw; v.e_ren = e_ren; v.e_wen = e_wen;
        v.e_addr = e_addr; v.e_store = e_store; v.e_il = e_il; v.e_dl = e_dl;
        return v;
    endfunction

    task automatic drive(input logic ir, dr, dw, input logic [31:0] ia, da, ds,
                         input logic [1:0] rs, input logic [31:0] rl);
        bus.iREN = ir; bus.dREN = dr; bus.dWEN = dw;
        bus.iaddr = ia; bus.daddr = da; bus.dstore = ds;
        bus.ramstate = ramstate_t'(rs); bus.ramload = rl;
    endtask

    task automatic chk_outs(input string tag, input logic e_iw, e_dw, e_ren, e_wen,
                            input logic [31:0] e_addr, e_store, e_il, e_dl);
        chk({tag, "_iwait"},    bus.iwait,    e_iw);
        chk({tag, "_dwait"},    bus.dwait,    e_dw);
        chk({tag, "_ramREN"},   bus.ramREN,   e_ren);
        chk({tag, "_ramWEN"},   bus.ramWEN,   e_wen);
        chk({tag, "_ramaddr"},  bus.ramaddr,  e_addr);
        chk({tag, "_ramstore"}, bus.ramstore, e_store);
        chk({tag, "_iload"},    bus.iload,    e_il);
        chk({tag, "_dload"},    bus.dload,    e_dl);
    endtask

    // requests asserted during reset must not leak onto the outputs
    task automatic do_reset();
        nRST = 1'b0;
        drive(1, 1, 1, 32'h11, 32'h22, 32'h33, 2'd2, 32'h44);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk_outs("reset", 1, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 2'd0, 0);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    // reference: who owns the RAM port and how many times dcache won while icache waited
    int owner;  // 0 none, 1 icache, 2 dcache
    int dwins;

    task automatic model_cycle(input string tag);
        logic ireq, dreq, acc, done;
        logic e_iw, e_dw, e_ren, e_wen;
        logic [31:0] e_addr, e_store, e_il, e_dl;
        ireq = bus.iREN;
        dreq = bus.dREN | bus.dWEN;
        acc  = (bus.ramstate == ACCESS);
        done = 1'b0;
        e_iw = 1; e_dw = 1; e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0; e_il = 0; e_dl = 0;
        if (owner == 1) begin
            e_ren = ireq; e_addr = bus.iaddr;
            done = ireq && acc;
            if (done) begin e_iw = 0; e_il = bus.ramload; end
        end else if (owner == 2) begin
            e_wen = bus.dWEN; e_ren = bus.dREN && !bus.dWEN; e_addr = bus.daddr;
            e_store = bus.dWEN ? bus.dstore : 32'h0;
            done = dreq && acc;
            if (done) begin e_dw = 0; e_dl = bus.ramload; end
        end
        chk_outs(tag, e_iw, e_dw, e_ren, e_wen, e_addr, e_store, e_il, e_dl);
        chk({tag, "_one_grant"}, {31'b0, !bus.iwait && !bus.dwait}, 0);
        chk({tag, "_one_enable"}, {31'b0, bus.ramREN && bus.ramWEN}, 0);
        if (owner == 0) begin
            if (dreq && !(ireq && dwins == LIMIT)) begin
                owner = 2;
                dwins = ireq ? ((dwins < LIMIT) ? dwins + 1 : LIMIT) : 0;
            end else if (ireq) begin
                owner = 1;
                dwins = 0;
            end
        end else if ((owner == 1 && !ireq) || (owner == 2 && !dreq) || done) begin
            owner = 0;
        end
    endtask

    task automatic starve_run(input string tag);
        string got;
        int n;
        got = "";
        n = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge CLK);
            if (!bus.iwait && n < 10) begin got = {got, "I"}; n++; end
            else if (!bus.dwait && n < 10) begin got = {got, "D"}; n++; end
            chk({tag, "_one_grant"}, {31'b0, !bus.iwait && !bus.dwait}, 0);
            @(posedge CLK);
            #1;
        end
        checks++;
        if (got != "DDDDIDDDDI") begin
            errors++;
            $display("FAIL %s_sequence: got %s expected DDDDIDDDDI", tag, got);
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 2'd0, 0);
        do_reset();

        // icache read, dcache write+read, dcache BUSY stretch, icache withdrawal
        vecs.push_back(mk(1,0,0,'h40,0,0,2'd0,0,          1,1,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,'h40,0,0,2'd0,0,          1,1,1,0,'h40,0,0,0));
        vecs.push_back(mk(1,0,0,'h40,0,0,2'd2,'hDEADBEEF, 0,1,1,0,'h40,0,'hDEADBEEF,0));
        vecs.push_back(mk(0,0,0,'h40,0,0,2'd0,0,          1,1,0,0,0,0,0,0));
        vecs.push_back(mk(0,1,1,0,'h80,'h12345678,2'd0,0, 1,1,0,0,0,0,0,0));
        vecs.push_back(mk(0,1,1,0,'h80,'h12345678,2'd0,0, 1,1,0,1,'h80,'h12345678,0,0));
        vecs.push_back(mk(0,1,1,0,'h80,'h12345678,2'd2,'hCAFE0001, 1,0,0,1,'h80,'h12345678,0,'hCAFE0001));
        vecs.push_back(mk(0,0,0,0,'h80,0,2'd0,0,          1,1,0,0,0,0,0,0));
        vecs.push_back(mk(0,1,0,0,'h100,0,2'd0,0,         1,1,0,0,0,0,0,0));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(0,1,0,0,'h100,0,2'd1,'h77,  1,1,1,0,'h100,0,0,0));
        vecs.push_back(mk(0,1,0,0,'h100,0,2'd2,'h55AA,    1,0,1,0,'h100,0,0,'h55AA));
        vecs.push_back(mk(0,0,0,0,'h100,0,2'd0,0,         1,1,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,'h200,0,0,2'd0,0,         1,1,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,'h200,0,0,2'd1,0,         1,1,1,0,'h200,0,0,0));
        vecs.push_back(mk(0,0,0,'h200,0,0,2'd1,0,         1,1,0,0,'h200,0,0,0));
        vecs.push_back(mk(0,0,0,'h200,0,0,2'd2,'h99,      1,1,0,0,0,0,0,0));
        vecs.push_back(mk(0,1,0,0,'h300,0,2'd0,0,         1,1,0,0,0,0,0,0));
        vecs.push_back(mk(0,1,0,0,'h300,0,2'd3,'h99,      1,1,1,0,'h300,0,0,0));
        vecs.push_back(mk(0,1,0,0,'h300,0,2'd0,'h99,      1,1,1,0,'h300,0,0,0));
        vecs.push_back(mk(0,1,0,0,'h300,0,2'd2,'h1234,    1,0,1,0,'h300,0,0,'h1234));

        foreach (vecs[i]) begin
            drive(vecs[i].ir, vecs[i].dr, vecs[i].dw, vecs[i].ia, vecs[i].da, vecs[i].ds,
                  vecs[i].rs, vecs[i].rl);
            @(negedge CLK);
            chk_outs($sformatf("vec%0d", i), vecs[i].e_iw, vecs[i].e_dw, vecs[i].e_ren,
                     vecs[i].e_wen, vecs[i].e_addr, vecs[i].e_store, vecs[i].e_il, vecs[i].e_dl);
            @(posedge CLK);
            #1;
        end

        // push the starvation count to 4, then reset asynchronously mid-DSERV
        do_reset();
        drive(1, 1, 0, 'h400, 'h500, 0, 2'd2, 'h66);
        repeat (6) begin @(negedge CLK); @(posedge CLK); #1; end
        bus.ramstate = BUSY;
        @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("pre_rst_ramREN", bus.ramREN, 1);
        chk("pre_rst_dwait", bus.dwait, 1);
        #2 nRST = 1'b0;
        #1;
        chk_outs("async_rst", 1, 1, 0, 0, 0, 0, 0, 0);
        bus.ramstate = ACCESS;
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        chk_outs("rst_release", 1, 1, 0, 0, 0, 0, 0, 0);
        starve_run("starve");

        // randomized traffic against the reference
        do_reset();
        owner = 0;
        dwins = 0;
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                  $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)), $urandom);
            @(negedge CLK);
            model_cycle($sformatf("rnd%0d", c));
            @(posedge CLK);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
